// File: rtl/calc_controller_if.sv
// Bundle of signals between the keypad/ALU side and calc_controller.
// Latency: none, wires only. Backpressure: none; keys are one-cycle strobes that are never stalled.
// Ports: key_valid/key_code (key events), alu_result (arithmetic unit output),
//        first_digit/second_digit/operation (operands and opcode to the unit),
//        display/result_valid/err (to the display).
interface calc_controller_if #(
  parameter int WIDTH = 14
);
  logic             key_valid;
  logic [3:0]       key_code;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] first_digit;
  logic [WIDTH-1:0] second_digit;
  logic [1:0]       operation;
  logic [WIDTH-1:0] display;
  logic             result_valid;
  logic             err;

  // Keypad and arithmetic-unit side: produces key events and the result.
  modport master (
    output key_valid, key_code, alu_result,
    input  first_digit, second_digit, operation, display, result_valid, err
  );

  // Controller side.
  modport slave (
    input  key_valid, key_code, alu_result,
    output first_digit, second_digit, operation, display, result_valid, err
  );
endinterface

// File: rtl/calc_controller.sv
// Keypad sequencer for a 14-bit multiply/add/subtract calculator: builds decimal operands, picks the op, shows results.
// Latency: every sampled key is reflected on the registered outputs one cycle later; "=" yields a result two edges after its sample.
// Backpressure: none; keys arriving during the single compute cycle, or non-clear keys in the error state, are dropped.
// Ports: clk, rst (synchronous, active high); bus (slave modport) carries key_valid/key_code/alu_result in,
//        first_digit/second_digit/operation/display/result_valid/err out.
module calc_controller #(
  parameter int WIDTH      = 14,
  parameter int MAX_DIGITS = 4,
  parameter int MAX_VAL    = 9999
) (
  input logic              clk,
  input logic              rst,
  calc_controller_if.slave bus
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  localparam logic [3:0] K_MUL = 4'd10;
  localparam logic [3:0] K_SUB = 4'd12;
  localparam logic [3:0] K_EQ  = 4'd13;
  localparam logic [3:0] K_CLR = 4'd14;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_CALC = 3'd2,
    S_SHOW = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] first_q, first_nxt;
  logic [WIDTH-1:0] second_q, second_nxt;
  logic [WIDTH-1:0] display_q, display_nxt;
  logic [WIDTH-1:0] latched;
  logic [1:0]       op_q, op_nxt;
  logic [CW-1:0]    count_q, count_nxt;
  logic             err_q, err_nxt;
  logic             rv_q, rv_nxt;

  // ---------------------------------------------------------------------------
  // Key decode
  // ---------------------------------------------------------------------------
  logic       key_digit, key_op, key_eq, key_clr;
  logic [1:0] key_opcode;
  logic       room;

  assign key_digit = bus.key_valid && (bus.key_code <= 4'd9);
  assign key_op    = bus.key_valid && (bus.key_code >= K_MUL) && (bus.key_code <= K_SUB);
  assign key_eq    = bus.key_valid && (bus.key_code == K_EQ);
  assign key_clr   = bus.key_valid && (bus.key_code == K_CLR);
  // 10/11/12 -> 00/01/10: the low two bits minus 2 wrap into the opcode.
  assign key_opcode = bus.key_code[1:0] - 2'd2;
  assign room       = (count_q < CW'(MAX_DIGITS));

  // Decimal shift-in; with at most MAX_DIGITS digits the value never exceeds MAX_VAL.
  function automatic logic [WIDTH-1:0] append(input logic [WIDTH-1:0] v, input logic [3:0] d);
    return (v * WIDTH'(10)) + {{(WIDTH-4){1'b0}}, d};
  endfunction

  // ---------------------------------------------------------------------------
  // Range check at full precision, independent of the arithmetic unit's width.
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_full;
  logic [WIDTH:0]     sum_full;
  logic               range_err;

  always_comb begin
    prod_full = {{WIDTH{1'b0}}, first_q} * {{WIDTH{1'b0}}, second_q};
    sum_full  = {1'b0, first_q} + {1'b0, second_q};
    range_err = 1'b0;
    case (op_q)
      2'b00:   range_err = (prod_full > (2*WIDTH)'(MAX_VAL));
      2'b01:   range_err = (sum_full > (WIDTH+1)'(MAX_VAL));
      default: range_err = (second_q > first_q);
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register and all output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_A;
      first_q   <= '0;
      second_q  <= '0;
      display_q <= '0;
      count_q   <= '0;
      op_q      <= 2'b00;
      rv_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      first_q   <= first_nxt;
      second_q  <= second_nxt;
      display_q <= display_nxt;
      count_q   <= count_nxt;
      op_q      <= op_nxt;
      rv_q      <= rv_nxt;
      err_q     <= err_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_A: begin
        if (key_clr)     state_nxt = S_A;
        else if (key_op) state_nxt = S_B;
      end
      S_B: begin
        if (key_clr)                         state_nxt = S_A;
        else if (key_eq && count_q != '0)    state_nxt = S_CALC;
      end
      // Operands have been stable for the whole of this cycle.
      S_CALC:  state_nxt = range_err ? S_ERR : S_SHOW;
      S_SHOW: begin
        if (key_clr || key_digit) state_nxt = S_A;
        else if (key_op)          state_nxt = S_B;
      end
      S_ERR: begin
        if (key_clr) state_nxt = S_A;
      end
      default: state_nxt = S_A;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    first_nxt  = first_q;
    second_nxt = second_q;
    count_nxt  = count_q;
    op_nxt     = op_q;
    err_nxt    = err_q;
    rv_nxt     = 1'b0;
    latched    = display_q;

    case (state)
      S_A: begin
        if (key_clr) begin
          first_nxt  = '0;
          second_nxt = '0;
          count_nxt  = '0;
          latched    = '0;
        end else if (key_digit) begin
          if (room) begin
            first_nxt = append(first_q, bus.key_code);
            count_nxt = count_q + CW'(1);
          end
        end else if (key_op) begin
          op_nxt     = key_opcode;
          count_nxt  = '0;
          second_nxt = '0;
        end
      end

      S_B: begin
        if (key_clr) begin
          first_nxt  = '0;
          second_nxt = '0;
          count_nxt  = '0;
          latched    = '0;
        end else if (key_digit) begin
          if (room) begin
            second_nxt = append(second_q, bus.key_code);
            count_nxt  = count_q + CW'(1);
          end
        end else if (key_op && count_q == '0) begin
          // Operator corrected before any B digit was typed.
          op_nxt = key_opcode;
        end
      end

      S_CALC: begin
        if (range_err) begin
          latched = '0;
          err_nxt = 1'b1;
        end else begin
          latched = bus.alu_result;
          rv_nxt  = 1'b1;
        end
      end

      S_SHOW: begin
        if (key_clr) begin
          first_nxt  = '0;
          second_nxt = '0;
          count_nxt  = '0;
          latched    = '0;
        end else if (key_digit) begin
          // A digit after a result starts a fresh calculation.
          first_nxt  = {{(WIDTH-4){1'b0}}, bus.key_code};
          count_nxt  = CW'(1);
          second_nxt = '0;
        end else if (key_op) begin
          // Chaining: the shown result becomes operand A.
          first_nxt  = display_q;
          second_nxt = '0;
          count_nxt  = '0;
          op_nxt     = key_opcode;
        end
      end

      S_ERR: begin
        if (key_clr) begin
          first_nxt  = '0;
          second_nxt = '0;
          count_nxt  = '0;
          latched    = '0;
          err_nxt    = 1'b0;
        end
      end

      default: begin
        first_nxt  = '0;
        second_nxt = '0;
        count_nxt  = '0;
        latched    = '0;
        err_nxt    = 1'b0;
      end
    endcase

    // Display follows the operand being edited, judged on the state being entered
    // so that the key's effect shows on the very next cycle.
    case (state_nxt)
      S_A:     display_nxt = first_nxt;
      S_B:     display_nxt = (count_nxt == '0) ? first_nxt : second_nxt;
      default: display_nxt = latched;
    endcase
  end

  assign bus.first_digit  = first_q;
  assign bus.second_digit = second_q;
  assign bus.operation    = op_q;
  assign bus.display      = display_q;
  assign bus.result_valid = rv_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_calc_controller.sv
// Bench for calc_controller: directed key sequences followed by random key traffic.
// Expected outputs come from a behavioural calculator model; a monitor compares after each edge.
module tb_calc_controller;

  localparam int W = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;

  calc_controller_if #(.WIDTH(W)) bus ();

  calc_controller #(.WIDTH(W), .MAX_DIGITS(4), .MAX_VAL(9999)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Arithmetic unit: combinational, truncated to the datapath width.
  logic [2*W-1:0] alu_wide;
  always_comb begin
    case (bus.operation)
      2'b00:   alu_wide = (2*W)'(bus.first_digit) * (2*W)'(bus.second_digit);
      2'b01:   alu_wide = (2*W)'(bus.first_digit) + (2*W)'(bus.second_digit);
      default: alu_wide = (2*W)'(bus.first_digit) - (2*W)'(bus.second_digit);
    endcase
  end
  assign bus.alu_result = alu_wide[W-1:0];

  // ---------------------------------------------------------------------------
  // Behavioural calculator model
  // ---------------------------------------------------------------------------
  localparam int M_ENTER_A = 0, M_ENTER_B = 1, M_COMPUTE = 2, M_SHOW = 3, M_ERROR = 4;

  int m_mode, m_a, m_b, m_cnt, m_op, m_disp, m_err, m_rv;

  typedef struct {
    int first;
    int second;
    int op;
    int disp;
    int rv;
    int err;
  } snap_t;

  snap_t snap_q[$];
  int    res_q[$];

  int vectors    = 0;
  int miscompares = 0;

  task automatic model_clear();
    m_mode = M_ENTER_A;
    m_a = 0; m_b = 0; m_cnt = 0; m_disp = 0; m_err = 0;
  endtask

  task automatic model_step(input bit r, input bit v, input int k);
    int res;
    m_rv = 0;
    if (r) begin
      model_clear();
      m_op = 0;
    end else if (m_mode == M_COMPUTE) begin
      case (m_op)
        0:       res = m_a * m_b;
        1:       res = m_a + m_b;
        default: res = m_a - m_b;
      endcase
      if (res > 9999 || res < 0) begin
        m_disp = 0; m_err = 1; m_mode = M_ERROR;
      end else begin
        m_disp = res; m_rv = 1; m_mode = M_SHOW;
        res_q.push_back(res);
      end
    end else if (v && k != 15) begin
      if (k == 14) begin
        model_clear();
      end else if (m_mode == M_ERROR) begin
        // only clear is honoured while in error
      end else if (k <= 9) begin
        if (m_mode == M_ENTER_A && m_cnt < 4) begin
          m_a = m_a * 10 + k; m_cnt++;
        end else if (m_mode == M_ENTER_B && m_cnt < 4) begin
          m_b = m_b * 10 + k; m_cnt++;
        end else if (m_mode == M_SHOW) begin
          m_a = k; m_b = 0; m_cnt = 1; m_mode = M_ENTER_A;
        end
      end else if (k <= 12) begin
        if (m_mode == M_ENTER_A) begin
          m_op = k - 10; m_cnt = 0; m_b = 0; m_mode = M_ENTER_B;
        end else if (m_mode == M_ENTER_B && m_cnt == 0) begin
          m_op = k - 10;
        end else if (m_mode == M_SHOW) begin
          m_a = m_disp; m_b = 0; m_cnt = 0; m_op = k - 10; m_mode = M_ENTER_B;
        end
      end else if (k == 13) begin
        if (m_mode == M_ENTER_B && m_cnt > 0) m_mode = M_COMPUTE;
      end
    end
    if (m_mode == M_ENTER_A)      m_disp = m_a;
    else if (m_mode == M_ENTER_B) m_disp = (m_cnt == 0) ? m_a : m_b;
  endtask

  // One cycle of stimulus: drive away from the active edge, predict, queue the prediction.
  task automatic drive(input bit r, input bit v, input logic [3:0] k);
    snap_t s;
    @(negedge clk);
    rst = r;
    bus.key_valid = v;
    bus.key_code  = k;
    model_step(r, v, int'(k));
    s.first = m_a; s.second = m_b; s.op = m_op;
    s.disp = m_disp; s.rv = m_rv; s.err = m_err;
    snap_q.push_back(s);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  snap_t mon_e;
  always @(posedge clk) begin
    #1;
    if (snap_q.size() > 0) begin
      mon_e = snap_q.pop_front();
      chk("first_digit",  int'(bus.first_digit),  mon_e.first);
      chk("second_digit", int'(bus.second_digit), mon_e.second);
      chk("operation",    int'(bus.operation),    mon_e.op);
      chk("display",      int'(bus.display),      mon_e.disp);
      chk("result_valid", int'(bus.result_valid), mon_e.rv);
      chk("err",          int'(bus.err),          mon_e.err);
      if (bus.result_valid) begin
        if (res_q.size() == 0) chk("unexpected_result", int'(bus.display), -1);
        else                   chk("result_value", int'(bus.display), res_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  // -1 reset, -2 idle, -3 reset together with a digit key, -4 key_code toggling with key_valid low
  int dir[$] = '{
    -1, 1, 2, 11, 3, 4, 13, -2, -2, -2,
    9, 9, 9, 9, 10, 2, 13, -2, -2, 3, 10, 13, -2, 14, -2,
    5, 12, 7, 13, -2, -2, 14, 7, 12, 5, 13, -2, -2,
    14, 3, 10, 4, 13, -2, -2, 11, 1, 13, -2, -2,
    14, 1, 2, 3, 4, 5, 11, 12, 13, -2, 15, -2,
    1, 11, 2, -3, -2, 4, -4, -4, -4, -4, 15, 0, 0, 7, -2
  };

  initial begin
    int x, k;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
    m_op = 0;
    model_clear();
    m_rv = 0;

    foreach (dir[i]) begin
      case (dir[i])
        -1:      drive(1'b1, 1'b0, 4'd0);
        -2:      drive(1'b0, 1'b0, 4'd0);
        -3:      drive(1'b1, 1'b1, 4'd5);
        -4:      drive(1'b0, 1'b0, 4'($urandom_range(0, 15)));
        default: drive(1'b0, 1'b1, 4'(dir[i]));
      endcase
    end

    for (int n = 0; n < 3000; n++) begin
      x = $urandom_range(0, 99);
      if (x < 2) begin
        drive(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end else if (x < 15) begin
        drive(1'b0, 1'b0, 4'($urandom_range(0, 15)));
      end else begin
        x = $urandom_range(0, 99);
        if (x < 55)      k = $urandom_range(0, 9);
        else if (x < 70) k = 10 + $urandom_range(0, 2);
        else if (x < 85) k = 13;
        else if (x < 92) k = 14;
        else             k = 15;
        drive(1'b0, 1'b1, 4'(k));
      end
    end

    repeat (3) drive(1'b0, 1'b0, 4'd0);
    repeat (2) @(posedge clk);
    #2;
    chk("results_drained", res_q.size(), 0);
    chk("snapshots_drained", snap_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
